misr_periph: RTL and testbench
==============================

Name: misr_periph

Overview:
- Single MISR signature-compression peripheral on the CPU AXI path.
- Sits directly downstream of the address decoder, which supplies one re/we bit pair per instance. Two instances are used, at BASE_ADDR and BASE_ADDR + 3*(NBIT_MISR_DATA/8).
- Exposes three CSRs (CTRL, SEED, SIGNATURE).
- Compresses a trace stream into a signature over a programmed number of valid beats.

Parameters:
- NBIT_MISR_DATA, 64, CSR, trace and signature width.
- NBIT_MISR_ADDR, 64, address width.
- BASE_ADDR, 2**25, byte address of CTRL.
- POLY, 64'h1B, feedback polynomial. Only the low NBIT_MISR_DATA bits are used.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- re_i  in  1  CSR read strobe from the decoder, single cycle
- we_i  in  1  CSR write strobe from the decoder, single cycle
- addr_i  in  NBIT_MISR_ADDR  byte address
- wdata_i  in  NBIT_MISR_DATA  write data
- rdata_o  out  NBIT_MISR_DATA  read data
- rvalid_o  out  1  read data valid
- trace_valid_i  in  1  trace beat valid
- trace_data_i  in  NBIT_MISR_DATA  trace beat
- busy_o  out  1  state==RUN
- done_o  out  1  state==DONE

Behaviour:
- Reset (rst_i sampled high at a clock edge):
  - state=IDLE; seed, sig, count, length = 0.
  - rdata_o=0, rvalid_o=0, busy_o=0, done_o=0.
  - Reset mid-RUN aborts with no further signature update.
- CSR map, with B = NBIT_MISR_DATA/8:
  - CTRL @ BASE_ADDR
    - Write: bit0 START (self-clearing, not stored), bit1 ABORT (not stored), bits[63:32] LENGTH (stored).
    - Read: {LENGTH, 28'b0, done, busy, 2'b00}.
  - SEED @ BASE_ADDR+B: read/write.
  - SIGNATURE @ BASE_ADDR+2B: read-only; writes ignored.
- Unmapped address (any other value): write ignored; read returns 0 with rvalid_o=1.
- Read latency is 1 cycle:
  - re_i at edge N → rdata_o/rvalid_o valid in cycle N+1.
  - rvalid_o is high for exactly 1 cycle; rdata_o=0 when rvalid_o=0.
- re_i and we_i high together: the write executes, the read is dropped (rvalid_o stays 0).
- Reads return the value before any same-cycle update.
- Writes take effect at the edge where we_i is sampled.
- MISR step, applied once per trace_valid_i=1 cycle in RUN:
  - sig_next = {sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0) ^ trace_data_i.
  - count increments by 1; count is 32 bits.
- FSM states: IDLE, RUN, DONE.
  - IDLE or DONE, write CTRL with START=1:
    - sig<=SEED, count<=0, LENGTH<=wdata[63:32].
    - Next state RUN if the new LENGTH≠0, else DONE with sig=SEED.
    - SEED is read before any same-cycle write; only CTRL is written in that cycle.
  - RUN, trace_valid_i=1: step the MISR. If count==LENGTH-1, go to DONE on the same edge.
  - RUN, write CTRL with ABORT=1: go to IDLE, sig and count hold.
    - ABORT wins over a same-cycle trace beat; that beat is not compressed.
  - RUN, other cases:
    - START ignored.
    - Writes to SEED and CTRL.LENGTH ignored.
    - trace_valid_i=0 holds sig and count.
  - DONE: sig holds, trace beats ignored, done_o=1 until the next START.
  - IDLE: trace beats ignored; ABORT has no effect.
- SIGNATURE reads during RUN return the current, partial sig.
- count never wraps: LENGTH ≤ 2^32-1 always terminates first.

Test Plan:
1. Reset → all outputs 0. Read CTRL → rvalid_o 1 cycle later, rdata=0.
2. SEED=0, CTRL={LENGTH=1, START}, one beat 0xA5 → done_o=1 after the beat edge; SIGNATURE reads 0x00000000000000A5.
3. SEED=0, LENGTH=2, beats 0x1 then 0x2 with a 3-cycle trace_valid_i gap between them → busy_o held through the gap; final SIGNATURE=0x0.
4. SEED=0x8000000000000000, LENGTH=1, beat 0x0 → SIGNATURE=0x1B. Re-run with LENGTH=0 and START → immediate DONE, SIGNATURE=SEED.
5. LENGTH=4, two beats, then ABORT in the same cycle as beat 3 → state IDLE, signature equals the 2-beat value, done_o=0. Write SEED during RUN → SEED read back unchanged.
6. re_i+we_i together to SEED with 0x55 → no rvalid, SEED=0x55. Read BASE_ADDR+3B → rdata 0, rvalid 1. rst_i mid-RUN → IDLE, sig=0 next cycle.

Source files
------------

// File: rtl/misr_periph.sv
// rtl/misr_periph.sv - MISR signature-compression peripheral with CTRL/SEED/SIGNATURE CSRs
// Compresses trace beats into a signature over a programmed number of valid beats.
module misr_periph #(
  parameter int unsigned                NBIT_MISR_DATA = 64,
  parameter int unsigned                NBIT_MISR_ADDR = 64,
  parameter logic [NBIT_MISR_ADDR-1:0]  BASE_ADDR      = 64'h0000_0000_0200_0000,
  parameter logic [NBIT_MISR_DATA-1:0]  POLY           = 64'h1B
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      re_i,
  input  logic                      we_i,
  input  logic [NBIT_MISR_ADDR-1:0] addr_i,
  input  logic [NBIT_MISR_DATA-1:0] wdata_i,
  output logic [NBIT_MISR_DATA-1:0] rdata_o,
  output logic                      rvalid_o,
  input  logic                      trace_valid_i,
  input  logic [NBIT_MISR_DATA-1:0] trace_data_i,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned W = NBIT_MISR_DATA;
  localparam logic [NBIT_MISR_ADDR-1:0] B_BYTES   = NBIT_MISR_ADDR'(NBIT_MISR_DATA / 8);
  localparam logic [NBIT_MISR_ADDR-1:0] CTRL_ADDR = BASE_ADDR;
  localparam logic [NBIT_MISR_ADDR-1:0] SEED_ADDR = BASE_ADDR + B_BYTES;
  localparam logic [NBIT_MISR_ADDR-1:0] SIG_ADDR  = BASE_ADDR + (B_BYTES << 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  seed_q, seed_d;
  logic [W-1:0]  sig_q, sig_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   length_q, length_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;

  logic          hit_ctrl, hit_seed, hit_sig;
  logic          wr_ctrl, wr_seed, rd_en;
  logic          start, abort;
  logic [31:0]   wr_length;
  logic [W-1:0]  sig_step;
  logic [W-1:0]  ctrl_rd;

  assign hit_ctrl  = (addr_i == CTRL_ADDR);
  assign hit_seed  = (addr_i == SEED_ADDR);
  assign hit_sig   = (addr_i == SIG_ADDR);
  assign wr_ctrl   = we_i & hit_ctrl;
  assign wr_seed   = we_i & hit_seed;
  // A write wins over a simultaneous read; the read is simply dropped.
  assign rd_en     = re_i & ~we_i;
  assign start     = wr_ctrl & wdata_i[0];
  assign abort     = wr_ctrl & wdata_i[1];
  assign wr_length = wdata_i[63:32];

  assign sig_step = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ trace_data_i;

  always_comb begin
    ctrl_rd        = '0;
    ctrl_rd[63:32] = length_q;
    ctrl_rd[3]     = (state_q == ST_DONE);
    ctrl_rd[2]     = (state_q == ST_RUN);
  end

  always_comb begin
    rdata_d  = '0;
    rvalid_d = rd_en;
    if (rd_en) begin
      if (hit_ctrl)      rdata_d = ctrl_rd;
      else if (hit_seed) rdata_d = seed_q;
      else if (hit_sig)  rdata_d = sig_q;
      else               rdata_d = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    sig_d    = sig_q;
    count_d  = count_q;
    length_d = length_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (wr_ctrl) length_d = wr_length;
        if (wr_seed) seed_d = wdata_i;
        if (start) begin
          sig_d   = seed_q;
          count_d = '0;
          state_d = (wr_length != 32'd0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        // Abort takes priority: a beat arriving in the same cycle is discarded.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (trace_valid_i) begin
          sig_d   = sig_step;
          count_d = count_q + 32'd1;
          if (count_q == length_q - 32'd1) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      seed_q   <= '0;
      sig_q    <= '0;
      count_q  <= '0;
      length_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      sig_q    <= sig_d;
      count_q  <= count_d;
      length_q <= length_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign busy_o   = (state_q == ST_RUN);
  assign done_o   = (state_q == ST_DONE);

endmodule

// File: tb/tb_misr_periph.sv
// tb/tb_misr_periph.sv - directed self-checking bench for misr_periph
module tb_misr_periph;

  localparam int unsigned W = 64;
  localparam int unsigned A = 64;
  localparam logic [A-1:0] BASE = 64'h0000_0000_0200_0000;
  localparam logic [A-1:0] CTRL = BASE;
  localparam logic [A-1:0] SEED = BASE + 64'd8;
  localparam logic [A-1:0] SIG  = BASE + 64'd16;
  localparam logic [A-1:0] UNMP = BASE + 64'd24;

  logic         clk;
  logic         rst;
  logic         re;
  logic         we;
  logic [A-1:0] addr;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         rvalid;
  logic         tvalid;
  logic [W-1:0] tdata;
  logic         busy;
  logic         done;

  int n_cmp;
  int n_err;
  logic [W-1:0] rd_val;
  logic         rd_vld;

  misr_periph dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .re_i          (re),
    .we_i          (we),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .rdata_o       (rdata),
    .rvalid_o      (rvalid),
    .trace_valid_i (tvalid),
    .trace_data_i  (tdata),
    .busy_o        (busy),
    .done_o        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h want 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ctrl_word(input logic [31:0] len, input logic ab, input logic st);
    ctrl_word = {len, 30'd0, ab, st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [A-1:0] a, input logic [W-1:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic csr_read(input logic [A-1:0] a, output logic [W-1:0] d, output logic v);
    re = 1'b1; addr = a;
    tick();
    re = 1'b0;
    d = rdata;
    v = rvalid;
  endtask

  task automatic beat(input logic [W-1:0] d);
    tvalid = 1'b1; tdata = d;
    tick();
    tvalid = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    tvalid = 1'b0; tdata = '0;
    tick(); tick();
    rst = 1'b0;

    // 1: reset state and first read latency
    check("rst_rdata", rdata, 64'd0);
    check("rst_rvalid", {63'd0, rvalid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    csr_read(CTRL, rd_val, rd_vld);
    check("t1_ctrl_rvalid", {63'd0, rd_vld}, 64'd1);
    check("t1_ctrl_rdata", rd_val, 64'd0);
    tick();
    check("t1_rvalid_one_cycle", {63'd0, rvalid}, 64'd0);

    // 2: single beat
    csr_write(SEED, 64'd0);
    csr_write(CTRL, ctrl_word(32'd1, 1'b0, 1'b1));
    check("t2_busy", {63'd0, busy}, 64'd1);
    beat(64'hA5);
    check("t2_done", {63'd0, done}, 64'd1);
    check("t2_busy_off", {63'd0, busy}, 64'd0);
    csr_read(SIG, rd_val, rd_vld);
    check("t2_sig", rd_val, 64'h0000_0000_0000_00A5);
    csr_read(CTRL, rd_val, rd_vld);
    check("t2_ctrl", rd_val, 64'h0000_0001_0000_0008);

    // 3: gap between beats
    csr_write(CTRL, ctrl_word(32'd2, 1'b0, 1'b1));
    beat(64'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_busy_gap", {63'd0, busy}, 64'd1);
    end
    beat(64'h2);
    check("t3_done", {63'd0, done}, 64'd1);
    csr_read(SIG, rd_val, rd_vld);
    check("t3_sig", rd_val, 64'h0);

    // 4: polynomial feedback, then zero length
    csr_write(SEED, 64'h8000_0000_0000_0000);
    csr_write(CTRL, ctrl_word(32'd1, 1'b0, 1'b1));
    beat(64'h0);
    csr_read(SIG, rd_val, rd_vld);
    check("t4_sig_poly", rd_val, 64'h1B);
    csr_write(CTRL, ctrl_word(32'd0, 1'b0, 1'b1));
    check("t4_len0_done", {63'd0, done}, 64'd1);
    check("t4_len0_busy", {63'd0, busy}, 64'd0);
    csr_read(SIG, rd_val, rd_vld);
    check("t4_len0_sig", rd_val, 64'h8000_0000_0000_0000);

    // 5: abort beats a same-cycle beat; SEED locked during RUN
    csr_write(SEED, 64'd0);
    csr_write(CTRL, ctrl_word(32'd4, 1'b0, 1'b1));
    beat(64'h10);
    beat(64'h01);
    csr_read(SIG, rd_val, rd_vld);
    check("t5_partial_sig", rd_val, 64'h21);
    csr_write(SEED, 64'h1234);
    csr_read(SEED, rd_val, rd_vld);
    check("t5_seed_locked", rd_val, 64'd0);
    tvalid = 1'b1; tdata = 64'hFF;
    we = 1'b1; addr = CTRL; wdata = ctrl_word(32'd0, 1'b1, 1'b0);
    tick();
    tvalid = 1'b0; we = 1'b0;
    check("t5_abort_busy", {63'd0, busy}, 64'd0);
    check("t5_abort_done", {63'd0, done}, 64'd0);
    csr_read(SIG, rd_val, rd_vld);
    check("t5_abort_sig", rd_val, 64'h21);
    csr_read(CTRL, rd_val, rd_vld);
    check("t5_ctrl_idle", rd_val, 64'h0000_0004_0000_0000);
    beat(64'hFF);
    csr_read(SIG, rd_val, rd_vld);
    check("t5_idle_beat_ignored", rd_val, 64'h21);

    // 6: re+we collision, unmapped read, reset mid-RUN
    re = 1'b1; we = 1'b1; addr = SEED; wdata = 64'h55;
    tick();
    re = 1'b0; we = 1'b0;
    check("t6_collide_rvalid", {63'd0, rvalid}, 64'd0);
    csr_read(SEED, rd_val, rd_vld);
    check("t6_seed", rd_val, 64'h55);
    csr_read(UNMP, rd_val, rd_vld);
    check("t6_unmapped_rvalid", {63'd0, rd_vld}, 64'd1);
    check("t6_unmapped_rdata", rd_val, 64'd0);
    csr_write(UNMP, 64'hDEAD);
    csr_write(CTRL, ctrl_word(32'd5, 1'b0, 1'b1));
    beat(64'h3);
    check("t6_run_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_busy", {63'd0, busy}, 64'd0);
    check("t6_rst_done", {63'd0, done}, 64'd0);
    csr_read(SIG, rd_val, rd_vld);
    check("t6_rst_sig", rd_val, 64'd0);
    csr_read(SEED, rd_val, rd_vld);
    check("t6_rst_seed", rd_val, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
